// File: rtl/uart_rx_apb_ctrl.sv
// APB register front-end for a uart_rx receiver: enable control, an 8-entry
// receive FIFO with per-frame error flags, sticky status and a level/error interrupt.
module uart_rx_apb_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        rx_enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_busy,
  input  logic        parity_error,
  input  logic        framing_error,
  output logic        irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] r_thresh;
  logic             r_en;
  logic             r_ie_lvl;
  logic             r_ie_err;
  logic             r_ie_ovr;
  logic             r_ovr;
  logic             r_perr;
  logic             r_ferr;
  logic             r_pop_pend;
  logic             r_irq;
  logic [31:0]      r_prdata;
  logic             r_pslverr;

  logic             w_mapped;
  logic [1:0]       w_reg;
  logic             w_setup;
  logic             w_setup_rd;
  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_wr_thresh;
  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ovr_set;
  logic [LVL_W-1:0] w_thresh_eff;
  logic [9:0]       w_head;
  logic [31:0]      w_status;
  logic [31:0]      w_data_word;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_mapped    = (paddr[7:4] == 4'h0);
  assign w_reg       = paddr[3:2];
  assign w_setup     = psel & ~penable;
  assign w_setup_rd  = w_setup & ~pwrite;
  assign w_wr        = psel & penable & pwrite & w_mapped;
  assign w_wr_ctrl   = w_wr & (w_reg == ADDR_CTRL);
  assign w_wr_status = w_wr & (w_reg == ADDR_STATUS);
  assign w_wr_thresh = w_wr & (w_reg == ADDR_THRESH);
  assign w_flush     = w_wr_ctrl & pwdata[4];

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH_L);

  // A pop only happens if the setup-phase read actually returned a valid entry,
  // so a frame landing between setup and access is never silently consumed.
  assign w_pop     = psel & penable & ~pwrite & w_mapped & (w_reg == ADDR_DATA) & r_pop_pend;
  assign w_push    = rx_done & ~w_flush & (~w_full | w_pop);
  assign w_ovr_set = rx_done & ~w_flush & w_full & ~w_pop;

  always_comb begin
    w_thresh_eff = r_thresh;
    if (r_thresh == '0) begin
      w_thresh_eff = LVL_W'(1);
    end else if (r_thresh > DEPTH_L) begin
      w_thresh_eff = DEPTH_L;
    end
  end

  assign w_head = r_mem[r_rptr];

  always_comb begin
    w_status              = '0;
    w_status[0]           = ~w_empty;
    w_status[1]           = w_full;
    w_status[2]           = rx_busy;
    w_status[3]           = r_ovr;
    w_status[4]           = r_perr;
    w_status[5]           = r_ferr;
    w_status[LVL_W+7:8]   = r_level;
  end

  always_comb begin
    w_data_word = '0;
    if (!w_empty) begin
      w_data_word[9:0] = w_head;
      w_data_word[31]  = 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      ADDR_CTRL:   w_rdata[3:0] = {r_ie_ovr, r_ie_err, r_ie_lvl, r_en};
      ADDR_STATUS: w_rdata = w_status;
      ADDR_DATA:   w_rdata = w_data_word;
      ADDR_THRESH: w_rdata[LVL_W-1:0] = r_thresh;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {framing_error, parity_error, rx_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_ie_lvl <= 1'b0;
      r_ie_err <= 1'b0;
      r_ie_ovr <= 1'b0;
      r_thresh <= LVL_W'(1);
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= pwdata[0];
        r_ie_lvl <= pwdata[1];
        r_ie_err <= pwdata[2];
        r_ie_ovr <= pwdata[3];
      end
      if (w_wr_thresh) begin
        r_thresh <= pwdata[LVL_W-1:0];
      end
    end
  end

  // Hardware set dominates a coincident software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set | (r_ovr & ~(w_wr_status & pwdata[3]));
      r_perr <= (rx_done & parity_error) | (r_perr & ~(w_wr_status & pwdata[4]));
      r_ferr <= (rx_done & framing_error) | (r_ferr & ~(w_wr_status & pwdata[5]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prdata   <= '0;
      r_pslverr  <= 1'b0;
      r_pop_pend <= 1'b0;
    end else begin
      if (w_setup_rd) begin
        r_prdata <= w_mapped ? w_rdata : 32'd0;
      end
      r_pslverr  <= w_setup & ~w_mapped;
      r_pop_pend <= w_setup_rd & w_mapped & (w_reg == ADDR_DATA) & ~w_empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_ie_lvl & (r_level >= w_thresh_eff))
             | (r_ie_err & (r_perr | r_ferr))
             | (r_ie_ovr & r_ovr);
    end
  end

  assign prdata    = r_prdata;
  assign pready    = 1'b1;
  assign pslverr   = r_pslverr;
  assign rx_enable = r_en;
  assign irq       = r_irq;

  assign w_unused = ^{pwdata[31:6], paddr[1:0]};

endmodule
